calc_cmd_sequencer: RTL and testbench
=====================================

# calc_cmd_sequencer

Initiator-side front end for the arithmetic calculator datapath. It accepts opcode/operand commands over a valid/ready port, drives the calculator's one-hot operation strobes and operands, samples the result after a fixed latency, and returns it over a valid/ready response port. Each response carries a locally computed overflow flag and a result-mismatch flag. The block sits between the command source (test sequencer or CPU glue) and the calculator instance.

## Interface
- WIDTH, 3: operand/result width in bits.
- LAT, 1: calculator result latency in clock cycles, legal range 1..15.

- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- cmd_valid  input  1  command offered
- cmd_ready  output  1  command accepted when high together with cmd_valid
- cmd_op  input  2  00 add, 01 subtract, 10 shift left by 1, 11 shift right by 1
- cmd_a  input  WIDTH  first operand
- cmd_b  input  WIDTH  second operand; ignored for shifts
- op1, op2, op3, op4  output  1 each  one-hot strobes to calculator, mapped to opcodes 00/01/10/11
- calc_in1, calc_in2  output  WIDTH  operands to calculator
- calc_out  input  WIDTH  calculator result
- rsp_valid  output  1  response available
- rsp_ready  input  1  response consumed when high together with rsp_valid
- rsp_data  output  WIDTH  sampled calc_out
- rsp_ovf  output  1  overflow/borrow/shift-out of the operation
- rsp_mismatch  output  1  rsp_data differs from the locally computed truncated result
- rsp_count  output  8  number of completed responses, wraps

## Operation
- FSM states: IDLE, DRIVE, RESP.
- IDLE: cmd_ready=1. On cmd_valid & cmd_ready, latch op/a/b, load wait counter with LAT, go to DRIVE.
- DRIVE: exactly one of op1..op4 high, according to the latched op. calc_in1=a, calc_in2=b, held stable. Counter decrements each cycle. When it reaches 1, sample calc_out into rsp_data at that edge and go to RESP.
- RESP: rsp_valid=1. Strobes are low; rsp_data/ovf/mismatch are held. On rsp_ready, increment rsp_count and go to IDLE.
- cmd_ready=0 in DRIVE and RESP. Only one command is in flight.
- Local reference result is computed at WIDTH+1 bits:
  - add: a+b; ovf = carry out.
  - sub: a−b; ovf = borrow (a<b).
  - shl: a<<1; ovf = a[WIDTH-1].
  - shr: a>>1; ovf = 0, because the lost LSB is not overflow.
- rsp_mismatch = (sampled calc_out != low WIDTH bits of the reference result).
- Overflow never saturates. Results are truncated modulo 2^WIDTH.
- rsp_count wraps from 255 to 0.

## Timing
- Reset (synchronous, priority over everything):
  - state returns to IDLE.
  - op1..op4, calc_in1/2, rsp_valid, rsp_data, rsp_ovf, rsp_mismatch, rsp_count all go to 0.
  - cmd_ready is forced to 0 while reset is high and reads 1 in the first cycle after reset drops.
- A command accepted at edge E0 causes the following:
  - Strobe and operands are valid in cycles E0..E0+LAT.
  - calc_out is sampled at edge E0+LAT.
  - rsp_valid is high from E0+LAT.
- Strobes drop at the same edge rsp_valid rises. There is no overlap cycle.
- Minimum command-to-command spacing is LAT+2 cycles: accept, LAT drive cycles, one response cycle, with rsp_ready held high.
- rsp_ready held low stalls in RESP indefinitely. Outputs stay stable and cmd_ready stays 0.
- cmd_valid while cmd_ready=0 is ignored; the source must hold the command.
- Reset mid-DRIVE or mid-RESP aborts the command. No response is produced and rsp_count is unchanged from 0.

## Test plan
- LAT=1, add a=001 b=111, calculator model returns 000 -> rsp_data=000, rsp_ovf=1, rsp_mismatch=0, op1 high for exactly 1 cycle, rsp_valid 1 cycle after accept.
- Sub a=000 b=001, model returns 111 -> rsp_ovf=1, mismatch=0. Repeat with the model forced to return 000 -> rsp_mismatch=1.
- Shl a=110 -> expect 100 with ovf=1. Shr a=011 -> expect 001 with ovf=0; op4 is the only strobe asserted.
- LAT=4 with rsp_ready low for 10 cycles:
  - strobe high exactly 4 cycles.
  - rsp_valid held and rsp_data stable throughout the stall.
  - cmd_ready=0 until the cycle after the rsp handshake.
- Assert reset during DRIVE (LAT=4, cycle 2) -> all outputs 0 on the next edge, no rsp_valid, rsp_count=0, new command accepted normally afterwards.
- 257 back-to-back commands with rsp_ready tied high -> rsp_count=1 at the end (wrap), spacing exactly LAT+2 cycles.

Source files
------------

// File: rtl/calc_cmd_sequencer.sv
// calc_cmd_sequencer: initiator-side front end for the arithmetic calculator.
// Accepts one opcode/operand command at a time, drives the calculator's
// one-hot strobes and operands for LAT cycles, samples the result, checks it
// against a locally computed reference and returns it over a response port.
module calc_cmd_sequencer #(
    parameter int WIDTH = 3,
    parameter int LAT   = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic             op1,
    output logic             op2,
    output logic             op3,
    output logic             op4,
    output logic [WIDTH-1:0] calc_in1,
    output logic [WIDTH-1:0] calc_in2,
    input  logic [WIDTH-1:0] calc_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_ovf,
    output logic             rsp_mismatch,
    output logic [7:0]       rsp_count
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    // Wait counter load value; LAT is limited to 1..15 so four bits suffice.
    localparam logic [3:0] LAT_INIT = 4'(LAT);

    // Reference result at WIDTH+1 bits; the top bit is the carry, borrow or
    // shifted-out bit. A right shift loses its LSB, which is not overflow.
    function automatic logic [WIDTH:0] ref_result(
        input logic [1:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH:0] r;
        case (op)
            2'b00:   r = {1'b0, a} + {1'b0, b};
            2'b01:   r = {1'b0, a} - {1'b0, b};
            2'b10:   r = {a, 1'b0};
            2'b11:   r = {2'b00, a[WIDTH-1:1]};
            default: r = {(WIDTH+1){1'b0}};
        endcase
        return r;
    endfunction

    // One-hot strobe pattern for an opcode, bit 0 = op1 ... bit 3 = op4.
    function automatic logic [3:0] op_onehot(input logic [1:0] op);
        logic [3:0] s;
        case (op)
            2'b00:   s = 4'b0001;
            2'b01:   s = 4'b0010;
            2'b10:   s = 4'b0100;
            2'b11:   s = 4'b1000;
            default: s = 4'b0000;
        endcase
        return s;
    endfunction

    logic [1:0]       state_q,    state_d;
    logic [1:0]       op_q,       op_d;
    logic [WIDTH-1:0] a_q,        a_d;
    logic [WIDTH-1:0] b_q,        b_d;
    logic [3:0]       cnt_q,      cnt_d;
    logic [3:0]       strobe_q,   strobe_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_ovf_q,  rsp_ovf_d;
    logic             rsp_mm_q,   rsp_mm_d;
    logic [7:0]       rsp_cnt_q,  rsp_cnt_d;
    logic [WIDTH:0]   ref_s;
    logic             accept_s;

    // Ready is a decode of IDLE, gated off while reset is asserted so it
    // reads 1 as soon as reset drops.
    assign cmd_ready = (state_q == ST_IDLE) && !reset;
    assign accept_s  = cmd_valid && cmd_ready;
    assign ref_s     = ref_result(op_q, a_q, b_q);

    assign op1          = strobe_q[0];
    assign op2          = strobe_q[1];
    assign op3          = strobe_q[2];
    assign op4          = strobe_q[3];
    assign calc_in1     = a_q;
    assign calc_in2     = b_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_ovf      = rsp_ovf_q;
    assign rsp_mismatch = rsp_mm_q;
    assign rsp_count    = rsp_cnt_q;

    // Next-state logic for the IDLE/DRIVE/RESP command sequencer.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        cnt_d       = cnt_q;
        strobe_d    = strobe_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_ovf_d   = rsp_ovf_q;
        rsp_mm_d    = rsp_mm_q;
        rsp_cnt_d   = rsp_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d  = ST_DRIVE;
                    op_d     = cmd_op;
                    a_d      = cmd_a;
                    b_d      = cmd_b;
                    cnt_d    = LAT_INIT;
                    strobe_d = op_onehot(cmd_op);
                end else begin
                    strobe_d = 4'b0000;
                end
            end
            ST_DRIVE: begin
                // The last drive cycle samples the result; strobes drop on the
                // same edge that raises rsp_valid.
                if (cnt_q <= 4'd1) begin
                    state_d     = ST_RESP;
                    strobe_d    = 4'b0000;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = calc_out;
                    rsp_ovf_d   = ref_s[WIDTH];
                    rsp_mm_d    = (calc_out != ref_s[WIDTH-1:0]);
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_cnt_d   = rsp_cnt_q + 8'd1;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                strobe_d    = 4'b0000;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset that aborts any command.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= 2'b00;
            a_q         <= {WIDTH{1'b0}};
            b_q         <= {WIDTH{1'b0}};
            cnt_q       <= 4'd0;
            strobe_q    <= 4'b0000;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= {WIDTH{1'b0}};
            rsp_ovf_q   <= 1'b0;
            rsp_mm_q    <= 1'b0;
            rsp_cnt_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cnt_q       <= cnt_d;
            strobe_q    <= strobe_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_ovf_q   <= rsp_ovf_d;
            rsp_mm_q    <= rsp_mm_d;
            rsp_cnt_q   <= rsp_cnt_d;
        end
    end

endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// Testbench for calc_cmd_sequencer: a LAT=1 instance driven from a vector
// table plus back-to-back traffic, and a LAT=4 instance for stall and
// mid-command reset sequences. A small calculator model feeds calc_out.
module tb_calc_cmd_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] calc_model(input logic [3:0] s, input logic [2:0] x, input logic [2:0] y);
        case (s)
            4'b0001: return x + y;
            4'b0010: return x - y;
            4'b0100: return x << 1;
            4'b1000: return x >> 1;
            default: return 3'b000;
        endcase
    endfunction

    // shared command fields
    logic [1:0] cmd_op = 2'b00;
    logic [2:0] cmd_a  = 3'b000;
    logic [2:0] cmd_b  = 3'b000;

    // LAT=1 instance
    logic       r1 = 1'b1, c1_valid = 1'b0, c1_ready, rsp1_ready = 1'b1;
    logic       p1_1, p1_2, p1_3, p1_4, rsp1_valid, rsp1_ovf, rsp1_mm;
    logic [2:0] in1_1, in2_1, calc_out1, rsp1_data, ovr1_val = 3'b000;
    logic       ovr1_en = 1'b0;
    logic [7:0] rsp1_cnt;
    logic [3:0] str1;
    assign str1      = {p1_4, p1_3, p1_2, p1_1};
    assign calc_out1 = ovr1_en ? ovr1_val : calc_model(str1, in1_1, in2_1);

    calc_cmd_sequencer #(.WIDTH(3), .LAT(1)) dut1 (
        .clock(clk), .reset(r1), .cmd_valid(c1_valid), .cmd_ready(c1_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .op1(p1_1), .op2(p1_2), .op3(p1_3), .op4(p1_4),
        .calc_in1(in1_1), .calc_in2(in2_1), .calc_out(calc_out1),
        .rsp_valid(rsp1_valid), .rsp_ready(rsp1_ready), .rsp_data(rsp1_data),
        .rsp_ovf(rsp1_ovf), .rsp_mismatch(rsp1_mm), .rsp_count(rsp1_cnt)
    );

    // LAT=4 instance
    logic       r4 = 1'b1, c4_valid = 1'b0, c4_ready, rsp4_ready = 1'b0;
    logic       p4_1, p4_2, p4_3, p4_4, rsp4_valid, rsp4_ovf, rsp4_mm;
    logic [2:0] in1_4, in2_4, calc_out4, rsp4_data;
    logic [7:0] rsp4_cnt;
    logic [3:0] str4;
    assign str4      = {p4_4, p4_3, p4_2, p4_1};
    assign calc_out4 = calc_model(str4, in1_4, in2_4);

    calc_cmd_sequencer #(.WIDTH(3), .LAT(4)) dut4 (
        .clock(clk), .reset(r4), .cmd_valid(c4_valid), .cmd_ready(c4_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .op1(p4_1), .op2(p4_2), .op3(p4_3), .op4(p4_4),
        .calc_in1(in1_4), .calc_in2(in2_4), .calc_out(calc_out4),
        .rsp_valid(rsp4_valid), .rsp_ready(rsp4_ready), .rsp_data(rsp4_data),
        .rsp_ovf(rsp4_ovf), .rsp_mismatch(rsp4_mm), .rsp_count(rsp4_cnt)
    );

    typedef struct {
        logic [1:0] op;
        logic [2:0] a;
        logic [2:0] b;
        logic       ovr_en;
        logic [2:0] ovr_val;
        logic [2:0] exp_data;
        logic       exp_ovf;
        logic       exp_mm;
        logic [3:0] exp_str;
    } vec_t;

    vec_t vecs[10];

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_str, n_wait, nore, acc, last, cyc, bad_sp, bad_data;

        //          op     a       b       ovr   oval    data    ovf   mm    strobe
        vecs[0] = '{2'b00, 3'b001, 3'b111, 1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 4'b0001};
        vecs[1] = '{2'b01, 3'b000, 3'b001, 1'b0, 3'b000, 3'b111, 1'b1, 1'b0, 4'b0010};
        vecs[2] = '{2'b01, 3'b000, 3'b001, 1'b1, 3'b000, 3'b000, 1'b1, 1'b1, 4'b0010};
        vecs[3] = '{2'b10, 3'b110, 3'b011, 1'b0, 3'b000, 3'b100, 1'b1, 1'b0, 4'b0100};
        vecs[4] = '{2'b11, 3'b011, 3'b110, 1'b0, 3'b000, 3'b001, 1'b0, 1'b0, 4'b1000};
        vecs[5] = '{2'b00, 3'b010, 3'b011, 1'b0, 3'b000, 3'b101, 1'b0, 1'b0, 4'b0001};
        vecs[6] = '{2'b01, 3'b101, 3'b011, 1'b0, 3'b000, 3'b010, 1'b0, 1'b0, 4'b0010};
        vecs[7] = '{2'b11, 3'b111, 3'b101, 1'b0, 3'b000, 3'b011, 1'b0, 1'b0, 4'b1000};
        vecs[8] = '{2'b10, 3'b011, 3'b000, 1'b0, 3'b000, 3'b110, 1'b0, 1'b0, 4'b0100};
        vecs[9] = '{2'b00, 3'b111, 3'b001, 1'b1, 3'b101, 3'b101, 1'b1, 1'b1, 4'b0001};

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready1", c1_ready, 1'b0);
        chk("rst_ready4", c4_ready, 1'b0);
        chk("rst_strobes1", str1, 4'b0000);
        chk("rst_rsp_valid1", rsp1_valid, 1'b0);
        chk("rst_rsp_data1", rsp1_data, 3'b000);
        chk("rst_count1", rsp1_cnt, 8'd0);
        chk("rst_calc_in1", in1_1, 3'b000);
        chk("rst_count4", rsp4_cnt, 8'd0);
        r1 = 1'b0;
        r4 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_ready1", c1_ready, 1'b1);
        chk("post_rst_ready4", c4_ready, 1'b1);

        // ---------------- LAT=1 vector table ----------------
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("v%0d_cmd_ready", i), c1_ready, 1'b1);
            cmd_op   = vecs[i].op;
            cmd_a    = vecs[i].a;
            cmd_b    = vecs[i].b;
            ovr1_en  = vecs[i].ovr_en;
            ovr1_val = vecs[i].ovr_val;
            c1_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            c1_valid = 1'b0;
            chk($sformatf("v%0d_strobe", i), str1, vecs[i].exp_str);
            chk($sformatf("v%0d_early_valid", i), rsp1_valid, 1'b0);
            chk($sformatf("v%0d_busy_ready", i), c1_ready, 1'b0);
            chk($sformatf("v%0d_calc_in1", i), in1_1, vecs[i].a);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d_rsp_valid", i), rsp1_valid, 1'b1);
            chk($sformatf("v%0d_strobe_off", i), str1, 4'b0000);
            chk($sformatf("v%0d_data", i), rsp1_data, vecs[i].exp_data);
            chk($sformatf("v%0d_ovf", i), rsp1_ovf, vecs[i].exp_ovf);
            chk($sformatf("v%0d_mismatch", i), rsp1_mm, vecs[i].exp_mm);
            @(posedge clk);
            @(negedge clk);
            ovr1_en = 1'b0;
            chk($sformatf("v%0d_rsp_done", i), rsp1_valid, 1'b0);
            chk($sformatf("v%0d_count", i), rsp1_cnt, 8'(i + 1));
        end

        // ---------------- LAT=4 stall with rsp_ready low ----------------
        cmd_op   = 2'b00;
        cmd_a    = 3'b011;
        cmd_b    = 3'b010;
        c4_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        c4_valid = 1'b0;
        n_str  = 0;
        n_wait = 0;
        while (!rsp4_valid && n_wait < 20) begin
            if (str4 == 4'b0001) n_str++;
            n_wait++;
            @(negedge clk);
        end
        chk("lat4_strobe_cycles", n_str, 4);
        chk("lat4_valid_latency", n_wait, 4);
        chk("lat4_strobe_off", str4, 4'b0000);
        cmd_op   = 2'b01;
        cmd_a    = 3'b111;
        cmd_b    = 3'b001;
        c4_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("stall%0d_valid", i), rsp4_valid, 1'b1);
            chk($sformatf("stall%0d_data", i), rsp4_data, 3'b101);
            chk($sformatf("stall%0d_ovf", i), rsp4_ovf, 1'b0);
            chk($sformatf("stall%0d_ready", i), c4_ready, 1'b0);
            @(negedge clk);
        end
        c4_valid   = 1'b0;
        rsp4_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("stall_rsp_done", rsp4_valid, 1'b0);
        chk("stall_count", rsp4_cnt, 8'd1);
        chk("stall_ready_back", c4_ready, 1'b1);

        // ---------------- reset during DRIVE (LAT=4) ----------------
        cmd_op   = 2'b10;
        cmd_a    = 3'b101;
        cmd_b    = 3'b000;
        c4_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        c4_valid = 1'b0;
        chk("abort_strobe", str4, 4'b0100);
        @(posedge clk);
        @(negedge clk);
        r4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_strobes", str4, 4'b0000);
        chk("abort_calc_in1", in1_4, 3'b000);
        chk("abort_rsp_valid", rsp4_valid, 1'b0);
        chk("abort_rsp_data", rsp4_data, 3'b000);
        chk("abort_count", rsp4_cnt, 8'd0);
        chk("abort_ready_in_rst", c4_ready, 1'b0);
        r4 = 1'b0;
        nore = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (rsp4_valid) nore++;
        end
        chk("abort_no_rsp", nore, 0);
        chk("abort_ready_after", c4_ready, 1'b1);
        cmd_op   = 2'b01;
        cmd_a    = 3'b001;
        cmd_b    = 3'b011;
        c4_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        c4_valid = 1'b0;
        n_wait = 0;
        while (!rsp4_valid && n_wait < 20) begin
            n_wait++;
            @(negedge clk);
        end
        chk("after_abort_latency", n_wait, 4);
        chk("after_abort_data", rsp4_data, 3'b110);
        chk("after_abort_ovf", rsp4_ovf, 1'b1);
        chk("after_abort_mm", rsp4_mm, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("after_abort_count", rsp4_cnt, 8'd1);

        // ---------------- 257 back-to-back commands (LAT=1) ----------------
        r1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        r1 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("b2b_start_count", rsp1_cnt, 8'd0);
        cmd_op     = 2'b00;
        cmd_a      = 3'b001;
        cmd_b      = 3'b001;
        rsp1_ready = 1'b1;
        c1_valid   = 1'b1;
        acc = 0; last = -1; cyc = 0; bad_sp = 0; bad_data = 0;
        while (acc < 257 && cyc < 1000) begin
            if (rsp1_valid && rsp1_data !== 3'b010) bad_data++;
            if (c1_valid && c1_ready) begin
                if (last >= 0 && (cyc - last) != 3) bad_sp++;
                last = cyc;
                acc++;
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (acc == 257) c1_valid = 1'b0;
        end
        chk("b2b_accepts", acc, 257);
        chk("b2b_spacing_errors", bad_sp, 0);
        n_wait = 0;
        while (!rsp1_valid && n_wait < 10) begin
            n_wait++;
            @(negedge clk);
        end
        chk("b2b_last_valid", rsp1_valid, 1'b1);
        if (rsp1_valid && rsp1_data !== 3'b010) bad_data++;
        chk("b2b_data_errors", bad_data, 0);
        @(posedge clk);
        @(negedge clk);
        chk("b2b_count_wrap", rsp1_cnt, 8'd1);
        chk("b2b_idle_ready", c1_ready, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
